spi_slave: RTL and testbench
============================

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of raw_clk flops synchronising spi_sclk, spi_mosi and spi_cs_n (legal values 2-3).
REQ-002 SHALL have ports:
- raw_clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-high.
- width_16  input  1  word size: 0 = 8 bits, 1 = 16 bits.
- tx_data  input  16  word to transmit; only [7:0] is used in 8-bit mode.
- tx_load  input  1  one-cycle strobe that writes tx_data into the holding register.
- tx_pending  output  1  holding register is full and not yet consumed.
- rx_data  output  16  last complete received word; [15:8] = 0 in 8-bit mode.
- rx_ready  output  1  sticky; a new rx_data word is available.
- rx_ack  input  1  one-cycle strobe that clears rx_ready and overrun.
- overrun  output  1  sticky; a word completed while rx_ready = 1.
- underrun  output  1  sticky; a word started with tx_pending = 0.
- busy  output  1  synchronised chip-select is active (frame in progress).
- spi_sclk  input  1  external master clock (async).
- spi_mosi  input  1  external master data (async).
- spi_cs_n  input  1  external chip select, active low (async).
- spi_miso  output  1  slave data out.
- spi_miso_oe  output  1  output enable for spi_miso; equals busy.
REQ-003 SHALL operate as an SPI responder in mode 0 (CPOL = 0, CPHA = 0), MSB first; the block is the counterpart of the existing spi master.

Function
REQ-004 SHALL synchronise all three SPI inputs through SYNC_STAGES flops, then detect edges with one further registered stage; an external edge becomes visible internally SYNC_STAGES+1 raw_clk cycles later.
REQ-005 SHALL support a spi_sclk frequency up to raw_clk/8, with each high and low phase lasting at least 4 raw_clk cycles.
REQ-006 SHALL have three states: IDLE, ACTIVE and WAIT_HIGH.
- IDLE -> ACTIVE on a synchronised cs_n falling edge.
- ACTIVE -> IDLE on a synchronised cs_n rising edge.
- WAIT_HIGH -> IDLE when the synchronised cs_n = 1.
REQ-007 SHALL, on entering ACTIVE:
- latch width_16 into a frame-width register; width_16 changes mid-frame are ignored.
- clear the bit counter.
- load the word start (REQ-010).
REQ-008 SHALL, on each synchronised sclk rising edge in ACTIVE, shift spi_mosi into the LSB of the receive shift register and increment the bit counter.
REQ-009 SHALL, on the rising edge that makes the bit counter equal 8 (or 16):
- copy the word to rx_data, zero-extended in 8-bit mode.
- set rx_ready.
- set overrun if rx_ready was already 1 and rx_ack is not asserted in the same cycle.
- reset the bit counter to 0; the frame continues with the next word.
REQ-010 SHALL perform a word start at ACTIVE entry and on the falling sclk edge that follows word completion:
- if tx_pending = 1, load the transmit shift register from the holding register and clear tx_pending.
- otherwise, load 16'h0000 and set underrun.
REQ-011 SHALL, when tx_load coincides with a word start, use tx_data directly for the shift register, leave tx_pending = 0 and not set underrun.
REQ-012 SHALL, on each synchronised sclk falling edge in ACTIVE that is not a word start, shift the transmit register left by one.
REQ-013 SHALL drive spi_miso from bit 7 (8-bit frame) or bit 15 (16-bit frame) of the transmit shift register while ACTIVE; spi_miso SHALL be 0 otherwise.
REQ-014 SHALL, when tx_load occurs while tx_pending = 1 and no word start occurs that cycle, overwrite the holding register; tx_pending stays 1.
REQ-015 SHALL clear underrun on tx_load.
REQ-016 SHALL, on rx_ack, clear rx_ready and overrun. If a word completes in the same cycle, rx_ready stays 1, rx_data takes the new word and overrun is not set.
REQ-017 SHALL, when cs_n rises mid-word, discard the partial receive word, leave rx_data, rx_ready and tx_pending unchanged, and clear the bit counter.
REQ-018 SHALL ignore sclk edges outside ACTIVE.
REQ-019 SHALL, when a cs_n falling edge and an sclk edge are detected in the same raw_clk cycle, perform the ACTIVE entry only; that sclk edge is ignored.

Reset
REQ-020 SHALL, while reset = 1 at a raw_clk edge, force:
- state to WAIT_HIGH.
- rx_data, bit counter and both shift registers to 0.
- rx_ready, overrun, underrun and tx_pending to 0.
- spi_miso, spi_miso_oe and busy to 0.
- synchroniser flops to the idle pattern (cs_n = 1, sclk = 0, mosi = 0).
REQ-021 SHALL, after reset is released while spi_cs_n is held low mid-frame, remain in WAIT_HIGH and ignore all activity until cs_n is seen high; no partial word is reported.

Verification
REQ-022 SHALL pass these directed scenarios:
- 8-bit exchange: tx_load 0x00A5, master sends 0x3C -> master receives 0xA5; rx_data = 0x003C; rx_ready = 1; tx_pending = 0; underrun = 0.
- 16-bit, two words in one frame: hold 0x1234, reload 0xBEEF after the first word starts, master sends 0xCAFE then 0x0F0F -> master receives 0x1234 then 0xBEEF; overrun = 1 with no rx_ack between the words; rx_data = 0x0F0F.
- Underrun: no tx_load, 8-bit frame -> master receives 0x00; underrun = 1; a later tx_load clears it.
- Abort: cs_n rises after 5 bits -> rx_ready and rx_data unchanged; the next full frame is received correctly.
- Simultaneous rx_ack and word completion -> rx_ready = 1, overrun = 0, rx_data = new word.
- Reset mid-frame with cs_n held low -> all outputs 0; clocks ignored until cs_n cycles high then low.

Source files
------------

// File: rtl/spi_slave.sv
// SPI mode-0 responder (CPOL=0, CPHA=0, MSB first) clocked entirely by raw_clk.
// Exchanges 8- or 16-bit words through a one-deep transmit holding register.
module spi_slave #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        raw_clk,
    input  logic        reset,
    input  logic        width_16,
    input  logic [15:0] tx_data,
    input  logic        tx_load,
    output logic        tx_pending,
    output logic [15:0] rx_data,
    output logic        rx_ready,
    input  logic        rx_ack,
    output logic        overrun,
    output logic        underrun,
    output logic        busy,
    input  logic        spi_sclk,
    input  logic        spi_mosi,
    input  logic        spi_cs_n,
    output logic        spi_miso,
    output logic        spi_miso_oe
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ACTIVE    = 2'd1,
        WAIT_HIGH = 2'd2
    } state_t;

    localparam logic [4:0] SETTLE_CYCLES = 5'(SYNC_STAGES + 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   frame_16;
    logic [4:0]             bit_cnt;
    logic [15:0]            rx_shift;
    logic [15:0]            tx_shift;
    logic [15:0]            tx_hold;
    logic                   start_pend;

    logic        sclk_s, mosi_s, cs_s;
    logic        sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [15:0] rx_word;
    logic [4:0]  bit_cnt_next;
    logic        word_done;
    logic        word_start;

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign mosi_s    = mosi_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_rise   = cs_s & ~cs_d;
    assign cs_fall   = ~cs_s & cs_d;

    always_comb begin
        rx_word      = {rx_shift[14:0], mosi_s};
        bit_cnt_next = bit_cnt + 5'd1;
        word_done    = (state == ACTIVE) && !cs_rise && sclk_rise &&
                       (bit_cnt_next == (frame_16 ? 5'd16 : 5'd8));
        // A cs_n rise takes priority, so the trailing sclk fall of a frame starts no word.
        word_start   = ((state == IDLE) && cs_fall) ||
                       ((state == ACTIVE) && !cs_rise && start_pend && sclk_fall);
    end

    assign spi_miso_oe = busy;
    assign spi_miso    = busy & (frame_16 ? tx_shift[15] : tx_shift[7]);

    // NOTE: every register here is updated with <= so all reads see pre-edge values.
    always_ff @(posedge raw_clk) begin
        if (reset) begin
            state      <= WAIT_HIGH;
            sclk_sync  <= '0;
            mosi_sync  <= '0;
            cs_sync    <= '1;
            sclk_d     <= 1'b0;
            cs_d       <= 1'b1;
            frame_16   <= 1'b0;
            bit_cnt    <= '0;
            rx_shift   <= '0;
            tx_shift   <= '0;
            tx_hold    <= '0;
            start_pend <= 1'b0;
            rx_data    <= '0;
            rx_ready   <= 1'b0;
            overrun    <= 1'b0;
            underrun   <= 1'b0;
            tx_pending <= 1'b0;
            busy       <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;

            if (tx_load && !word_start) begin
                tx_hold    <= tx_data;
                tx_pending <= 1'b1;
            end
            if (tx_load) underrun <= 1'b0;
            if (rx_ack) begin
                rx_ready <= 1'b0;
                overrun  <= 1'b0;
            end

            case (state)
                // The bit counter times out the reset pattern still in the
                // synchroniser before cs_n is trusted to read high.
                WAIT_HIGH: begin
                    if (bit_cnt != SETTLE_CYCLES) begin
                        bit_cnt <= bit_cnt + 5'd1;
                    end else if (cs_s) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                    end
                end
                IDLE: begin
                    if (cs_fall) begin
                        state      <= ACTIVE;
                        busy       <= 1'b1;
                        frame_16   <= width_16;
                        bit_cnt    <= '0;
                        rx_shift   <= '0;
                        start_pend <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (cs_rise) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        bit_cnt    <= '0;
                        rx_shift   <= '0;
                        start_pend <= 1'b0;
                    end else begin
                        if (sclk_rise) begin
                            rx_shift <= rx_word;
                            if (word_done) begin
                                bit_cnt    <= '0;
                                rx_data    <= frame_16 ? rx_word : {8'h00, rx_word[7:0]};
                                rx_ready   <= 1'b1;
                                start_pend <= 1'b1;
                                if (rx_ready && !rx_ack) overrun <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt_next;
                            end
                        end
                        if (sclk_fall) begin
                            if (start_pend) start_pend <= 1'b0;
                            else            tx_shift   <= tx_shift << 1;
                        end
                    end
                end
                default: state <= WAIT_HIGH;
            endcase

            if (word_start) begin
                if (tx_load) begin
                    tx_shift   <= tx_data;
                    tx_pending <= 1'b0;
                end else if (tx_pending) begin
                    tx_shift   <= tx_hold;
                    tx_pending <= 1'b0;
                end else begin
                    tx_shift <= '0;
                    underrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a behavioural mode-0 master drives the SPI pins
// on the falling raw_clk edge; every expected value is hand-computed.
module tb_spi_slave;

    localparam int HALF = 4;

    logic        raw_clk;
    logic        reset;
    logic        width_16;
    logic [15:0] tx_data;
    logic        tx_load;
    logic        tx_pending;
    logic [15:0] rx_data;
    logic        rx_ready;
    logic        rx_ack;
    logic        overrun;
    logic        underrun;
    logic        busy;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic        spi_miso;
    logic        spi_miso_oe;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] got;
    logic [15:0] got2;

    spi_slave #(.SYNC_STAGES(2)) dut (
        .raw_clk     (raw_clk),
        .reset       (reset),
        .width_16    (width_16),
        .tx_data     (tx_data),
        .tx_load     (tx_load),
        .tx_pending  (tx_pending),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_ack      (rx_ack),
        .overrun     (overrun),
        .underrun    (underrun),
        .busy        (busy),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    initial raw_clk = 1'b0;
    always #5 raw_clk = ~raw_clk;

    task automatic check(input string tag, input logic [15:0] actual, input logic [15:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", tag, actual, expected);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge raw_clk);
    endtask

    task automatic load_tx(input logic [15:0] value);
        tx_data = value;
        tx_load = 1'b1;
        wait_cycles(1);
        tx_load = 1'b0;
    endtask

    task automatic pulse_ack();
        rx_ack = 1'b1;
        wait_cycles(1);
        rx_ack = 1'b0;
        wait_cycles(1);
    endtask

    task automatic frame_begin();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b0;
        wait_cycles(6);
    endtask

    // The master returns sclk low together with raising cs_n to end a frame.
    task automatic send_word(input int n, input logic [15:0] w, input logic end_frame,
                             input logic ack_last, output logic [15:0] miso_word);
        miso_word = '0;
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = w[i];
            wait_cycles(HALF);
            miso_word = {miso_word[14:0], spi_miso};
            spi_sclk = 1'b1;
            if (ack_last && i == 0) begin
                wait_cycles(2);
                rx_ack = 1'b1;
                wait_cycles(1);
                rx_ack = 1'b0;
                wait_cycles(HALF - 3);
            end else begin
                wait_cycles(HALF);
            end
            spi_sclk = 1'b0;
            if (end_frame && i == 0) spi_cs_n = 1'b1;
        end
    endtask

    initial begin
        reset    = 1'b1;
        width_16 = 1'b0;
        tx_data  = '0;
        tx_load  = 1'b0;
        rx_ack   = 1'b0;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        spi_cs_n = 1'b1;
        wait_cycles(3);
        check("rst_rx_data", rx_data, 16'h0000);
        check("rst_rx_ready", 16'(rx_ready), 16'h0);
        check("rst_pending", 16'(tx_pending), 16'h0);
        check("rst_busy", 16'(busy), 16'h0);
        check("rst_miso", 16'(spi_miso), 16'h0);
        reset = 1'b0;
        wait_cycles(8);

        // 8-bit exchange
        load_tx(16'h00A5);
        check("s1_pending_set", 16'(tx_pending), 16'h1);
        frame_begin();
        check("s1_busy", 16'(busy), 16'h1);
        check("s1_oe", 16'(spi_miso_oe), 16'h1);
        check("s1_miso_msb", 16'(spi_miso), 16'h1);
        check("s1_pending_used", 16'(tx_pending), 16'h0);
        send_word(8, 16'h003C, 1'b1, 1'b0, got);
        wait_cycles(8);
        check("s1_master_rx", got, 16'h00A5);
        check("s1_rx_data", rx_data, 16'h003C);
        check("s1_rx_ready", 16'(rx_ready), 16'h1);
        check("s1_underrun", 16'(underrun), 16'h0);
        check("s1_overrun", 16'(overrun), 16'h0);
        check("s1_busy_end", 16'(busy), 16'h0);
        check("s1_miso_end", 16'(spi_miso), 16'h0);
        pulse_ack();
        check("s1_ack", 16'(rx_ready), 16'h0);

        // 16-bit, two words per frame, width_16 dropped mid-frame
        load_tx(16'h1234);
        width_16 = 1'b1;
        frame_begin();
        width_16 = 1'b0;
        load_tx(16'hBEEF);
        check("s2_pending", 16'(tx_pending), 16'h1);
        send_word(16, 16'hCAFE, 1'b0, 1'b0, got);
        send_word(16, 16'h0F0F, 1'b1, 1'b0, got2);
        wait_cycles(8);
        check("s2_word1", got, 16'h1234);
        check("s2_word2", got2, 16'hBEEF);
        check("s2_rx_data", rx_data, 16'h0F0F);
        check("s2_overrun", 16'(overrun), 16'h1);
        check("s2_pending_end", 16'(tx_pending), 16'h0);
        check("s2_underrun", 16'(underrun), 16'h0);
        pulse_ack();
        check("s2_ack_overrun", 16'(overrun), 16'h0);

        // Underrun
        frame_begin();
        send_word(8, 16'h005A, 1'b1, 1'b0, got);
        wait_cycles(8);
        check("s3_master_rx", got, 16'h0000);
        check("s3_underrun", 16'(underrun), 16'h1);
        check("s3_rx_data", rx_data, 16'h005A);
        load_tx(16'h0077);
        check("s3_underrun_clr", 16'(underrun), 16'h0);

        // Abort after 5 bits
        frame_begin();
        send_word(5, 16'h001F, 1'b1, 1'b0, got);
        wait_cycles(8);
        check("s4_master_part", got, 16'h000E);
        check("s4_rx_ready", 16'(rx_ready), 16'h1);
        check("s4_rx_data", rx_data, 16'h005A);
        check("s4_pending", 16'(tx_pending), 16'h0);
        check("s4_busy", 16'(busy), 16'h0);

        // Next full frame, rx_ack coinciding with word completion
        load_tx(16'h0081);
        frame_begin();
        send_word(8, 16'h00C3, 1'b1, 1'b1, got);
        wait_cycles(8);
        check("s5_master_rx", got, 16'h0081);
        check("s5_rx_data", rx_data, 16'h00C3);
        check("s5_rx_ready", 16'(rx_ready), 16'h1);
        check("s5_overrun", 16'(overrun), 16'h0);

        // Reset mid-frame with cs_n held low
        load_tx(16'h00F0);
        frame_begin();
        load_tx(16'h0011);
        send_word(3, 16'h0005, 1'b0, 1'b0, got);
        reset = 1'b1;
        wait_cycles(2);
        check("s6_rst_rx_data", rx_data, 16'h0000);
        check("s6_rst_rx_ready", 16'(rx_ready), 16'h0);
        check("s6_rst_pending", 16'(tx_pending), 16'h0);
        check("s6_rst_busy", 16'(busy), 16'h0);
        check("s6_rst_oe", 16'(spi_miso_oe), 16'h0);
        reset = 1'b0;
        wait_cycles(4);
        send_word(8, 16'h00FF, 1'b0, 1'b0, got);
        wait_cycles(4);
        check("s6_ignored_rx", 16'(rx_ready), 16'h0);
        check("s6_ignored_data", rx_data, 16'h0000);
        check("s6_ignored_busy", 16'(busy), 16'h0);
        check("s6_ignored_miso", got, 16'h0000);
        check("s6_ignored_under", 16'(underrun), 16'h0);
        spi_cs_n = 1'b1;
        wait_cycles(8);
        load_tx(16'h0099);
        frame_begin();
        send_word(8, 16'h0066, 1'b1, 1'b0, got);
        wait_cycles(8);
        check("s6_master_rx", got, 16'h0099);
        check("s6_rx_data", rx_data, 16'h0066);
        check("s6_rx_ready", 16'(rx_ready), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
